div_result_fmt: RTL and testbench
=================================

# div_result_fmt

Downstream result stage for the 4-bit restoring divider. On the divider's completion pulse it captures the quotient and the 5-bit remainder register, converts each to two BCD digits with a sequential shift-add-3 (double-dabble) engine, and presents the digits to the display/consumer side under a valid/ready handshake. It decouples the divider from a consumer that may stall. Overrun and bad-remainder conditions are flagged.

## Interface
- No parameters; operand widths are fixed (quotient 4 bits, remainder 5 bits).
- clk  input  1  rising-edge clock, shared with the divider.
- rst  input  1  asynchronous, active-low reset.
- div_done  input  1  one-cycle pulse from the divider controller: quotient/remainder are final this cycle.
- quotient  input  4  divider quotient register.
- remainder  input  5  divider A register (remainder); bit 4 must be 0 for a valid result.
- out_ready  input  1  consumer accepts the result.
- out_valid  output  1  digit outputs hold a complete result.
- busy  output  1  high in CONV or HOLD.
- q_tens, q_ones, r_tens, r_ones  output  4 each  BCD digits of quotient and remainder[3:0].
- err  output  1  result-qualified: remainder[4] was 1 at capture.
- ovr  output  1  sticky: a div_done was dropped; cleared only by reset.

## Operation
- States: IDLE, CONV, HOLD.
- IDLE: div_done=1 → capture quotient, remainder[3:0] into binary shift registers, latch err_next=remainder[4], clear BCD scratch, iteration counter=0, go CONV.
- CONV: one double-dabble iteration per clock, both operands in parallel: for each operand, if ones nibble ≥5 add 3, then shift {tens,ones,bin} left by 1. After iteration 4 (counter 3→done), load digit outputs and err, go HOLD.
- HOLD: out_valid=1; digits and err stable. Edge with out_valid & out_ready = transfer → IDLE.
- Simultaneous: transfer edge with div_done=1 → capture new operands and go directly to CONV (no dropped result).
- div_done in CONV, or in HOLD without transfer → ignored, ovr set to 1.
- Value range 0..15: tens digit is 0 or 1; ones 0..9.
- err=1: digits still computed from remainder[3:0]; consumer decides.
- Digit outputs retain last transferred values in IDLE/CONV; only updated at end of CONV.

## Timing
- Reset (async, rst=0): state IDLE, out_valid=0, busy=0, all digits 0, err=0, ovr=0, counter 0. Reset mid-CONV or mid-HOLD aborts; no partial result is ever presented.
- Latency: div_done sampled on edge E → busy=1 after E; out_valid=1 after edge E+4 (4 CONV edges).
- Throughput: one result per 5 cycles with out_ready held 1.
- out_valid deasserts the cycle after the transfer edge unless a new capture occurred (then CONV, out_valid=0).
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- DIV_SEG7_EN defined: adds outputs seg_q_tens, seg_q_ones, seg_r_tens, seg_r_ones (7 bits each, bit6..0 = g,f,e,d,c,b,a, active-high), registered alongside the digits, reset 0. Tens displays blank (7'h00) when the digit is 0; ones always displayed (0 → 7'h3F). BCD value >9 is impossible; decoder defaults to blank.
- DIV_SEG7_EN undefined: segment ports and decoders absent; all other behaviour identical.

## Test plan
- Reset then div_done with quotient=13, remainder=5'b00010, out_ready=1 → out_valid after 4 edges, q=1/3, r=0/2, err=0; IDLE next cycle.
- quotient=15, remainder=5'b01001, out_ready=0 for 10 cycles → HOLD holds q=1/5, r=0/9 stable; div_done pulse during HOLD → ovr=1, result unchanged; then out_ready=1 → transfer.
- Back-to-back: div_done on the transfer edge (quotient=7, remainder=0) → straight to CONV, next result q=0/7, r=0/0, ovr stays 0.
- remainder=5'b10011 → err=1 with out_valid, r=0/3.
- rst=0 asserted mid-CONV → all outputs 0 immediately; no out_valid after release until a new div_done.
- With DIV_SEG7_EN: quotient=10, remainder=0 → seg_q_tens=7'h06, seg_q_ones=7'h3F, seg_r_tens=7'h00, seg_r_ones=7'h3F.

Source files
------------

// File: rtl/div_result_fmt.sv
// Result stage for the 4-bit restoring divider: captures quotient/remainder, converts to BCD
// with a 4-step double-dabble, and holds the digits under valid/ready. Optional DIV_SEG7_EN adds 7-segment outputs.
module div_result_fmt (
  input  logic       clk,
  input  logic       rst,
  input  logic       div_done,
  input  logic [3:0] quotient,
  input  logic [4:0] remainder,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       busy,
  output logic [3:0] q_tens,
  output logic [3:0] q_ones,
  output logic [3:0] r_tens,
  output logic [3:0] r_ones,
  output logic       err,
  output logic       ovr
`ifdef DIV_SEG7_EN
  ,
  output logic [6:0] seg_q_tens,
  output logic [6:0] seg_q_ones,
  output logic [6:0] seg_r_tens,
  output logic [6:0] seg_r_ones
`endif
);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t     state_q, state_d;
  logic [3:0] q_bin_q, q_bin_d, r_bin_q, r_bin_d;
  logic [7:0] q_sc_q, q_sc_d, r_sc_q, r_sc_d;
  logic [1:0] cnt_q, cnt_d;
  logic       err_cap_q, err_cap_d;
  logic [3:0] q_tens_q, q_tens_d, q_ones_q, q_ones_d;
  logic [3:0] r_tens_q, r_tens_d, r_ones_q, r_ones_d;
  logic       err_q, err_d, ovr_q, ovr_d;
  logic       out_valid_q, out_valid_d, busy_q, busy_d;

  logic [11:0] q_step, r_step;
  logic        capture, load, transfer;

  // One double-dabble iteration on {tens, ones, binary}: correct then shift.
  function automatic logic [11:0] dd_step(input logic [11:0] v);
    logic [3:0] t, o;
    t = v[11:8];
    o = v[7:4];
    if (o >= 4'd5) o = o + 4'd3;
    if (t >= 4'd5) t = t + 4'd3;
    return {t, o, v[3:0]} << 1;
  endfunction

  always_comb begin
    state_d     = state_q;
    q_bin_d     = q_bin_q;
    r_bin_d     = r_bin_q;
    q_sc_d      = q_sc_q;
    r_sc_d      = r_sc_q;
    cnt_d       = cnt_q;
    err_cap_d   = err_cap_q;
    q_tens_d    = q_tens_q;
    q_ones_d    = q_ones_q;
    r_tens_d    = r_tens_q;
    r_ones_d    = r_ones_q;
    err_d       = err_q;
    ovr_d       = ovr_q;
    capture     = 1'b0;
    load        = 1'b0;
    transfer    = out_valid_q & out_ready;
    q_step      = dd_step({q_sc_q, q_bin_q});
    r_step      = dd_step({r_sc_q, r_bin_q});

    case (state_q)
      IDLE: begin
        if (div_done) capture = 1'b1;
      end
      CONV: begin
        {q_sc_d, q_bin_d} = q_step;
        {r_sc_d, r_bin_d} = r_step;
        cnt_d = cnt_q + 2'd1;
        if (div_done) ovr_d = 1'b1;
        if (cnt_q == 2'd3) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (transfer) begin
          if (div_done) capture = 1'b1;
          else          state_d = IDLE;
        end else if (div_done) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      q_tens_d = q_step[11:8];
      q_ones_d = q_step[7:4];
      r_tens_d = r_step[11:8];
      r_ones_d = r_step[7:4];
      err_d    = err_cap_q;
    end

    // A capture from HOLD overrides the return to IDLE so no result is dropped.
    if (capture) begin
      q_bin_d   = quotient;
      r_bin_d   = remainder[3:0];
      err_cap_d = remainder[4];
      q_sc_d    = 8'd0;
      r_sc_d    = 8'd0;
      cnt_d     = 2'd0;
      state_d   = CONV;
    end

    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      q_bin_q     <= 4'd0;
      r_bin_q     <= 4'd0;
      q_sc_q      <= 8'd0;
      r_sc_q      <= 8'd0;
      cnt_q       <= 2'd0;
      err_cap_q   <= 1'b0;
      q_tens_q    <= 4'd0;
      q_ones_q    <= 4'd0;
      r_tens_q    <= 4'd0;
      r_ones_q    <= 4'd0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_bin_q     <= q_bin_d;
      r_bin_q     <= r_bin_d;
      q_sc_q      <= q_sc_d;
      r_sc_q      <= r_sc_d;
      cnt_q       <= cnt_d;
      err_cap_q   <= err_cap_d;
      q_tens_q    <= q_tens_d;
      q_ones_q    <= q_ones_d;
      r_tens_q    <= r_tens_d;
      r_ones_q    <= r_ones_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign q_tens    = q_tens_q;
  assign q_ones    = q_ones_q;
  assign r_tens    = r_tens_q;
  assign r_ones    = r_ones_q;
  assign err       = err_q;
  assign ovr       = ovr_q;

`ifdef DIV_SEG7_EN
  logic [6:0] seg_qt_q, seg_qt_d, seg_qo_q, seg_qo_d;
  logic [6:0] seg_rt_q, seg_rt_d, seg_ro_q, seg_ro_d;

  // Segment order g,f,e,d,c,b,a; a zero tens digit is blanked.
  function automatic logic [6:0] seg7(input logic [3:0] d, input logic blank_zero);
    case (d)
      4'd0:    seg7 = blank_zero ? 7'h00 : 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  always_comb begin
    seg_qt_d = seg_qt_q;
    seg_qo_d = seg_qo_q;
    seg_rt_d = seg_rt_q;
    seg_ro_d = seg_ro_q;
    if (load) begin
      seg_qt_d = seg7(q_step[11:8], 1'b1);
      seg_qo_d = seg7(q_step[7:4], 1'b0);
      seg_rt_d = seg7(r_step[11:8], 1'b1);
      seg_ro_d = seg7(r_step[7:4], 1'b0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_qt_q <= 7'h00;
      seg_qo_q <= 7'h00;
      seg_rt_q <= 7'h00;
      seg_ro_q <= 7'h00;
    end else begin
      seg_qt_q <= seg_qt_d;
      seg_qo_q <= seg_qo_d;
      seg_rt_q <= seg_rt_d;
      seg_ro_q <= seg_ro_d;
    end
  end

  assign seg_q_tens = seg_qt_q;
  assign seg_q_ones = seg_qo_q;
  assign seg_r_tens = seg_rt_q;
  assign seg_r_ones = seg_ro_q;
`endif

endmodule

// File: tb/tb_div_result_fmt.sv
// Directed bench for div_result_fmt: a queue of expected digit sets is filled at each div_done
// and drained on every valid/ready transfer; control behaviour is checked inline.
module tb_div_result_fmt;

  logic       clk = 1'b0;
  logic       rst;
  logic       div_done;
  logic [3:0] quotient;
  logic [4:0] remainder;
  logic       out_ready;
  logic       out_valid, busy, err, ovr;
  logic [3:0] q_tens, q_ones, r_tens, r_ones;
`ifdef DIV_SEG7_EN
  logic [6:0] seg_q_tens, seg_q_ones, seg_r_tens, seg_r_ones;
`endif

  div_result_fmt dut (
    .clk       (clk),
    .rst       (rst),
    .div_done  (div_done),
    .quotient  (quotient),
    .remainder (remainder),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .busy      (busy),
    .q_tens    (q_tens),
    .q_ones    (q_ones),
    .r_tens    (r_tens),
    .r_ones    (r_ones),
    .err       (err),
    .ovr       (ovr)
`ifdef DIV_SEG7_EN
    ,
    .seg_q_tens(seg_q_tens),
    .seg_q_ones(seg_q_ones),
    .seg_r_tens(seg_r_tens),
    .seg_r_ones(seg_r_ones)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] qt, qo, rt, ro;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_xfer = 0;
  int   lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference conversion by arithmetic, pushed as the expected transfer.
  task automatic push_exp(input logic [3:0] q, input logic [4:0] r);
    exp_t x;
    x.qt = 4'(q / 10);
    x.qo = 4'(q % 10);
    x.rt = 4'(r[3:0] / 10);
    x.ro = 4'(r[3:0] % 10);
    x.e  = r[4];
    sb.push_back(x);
  endtask

  // Sample at the falling edge (scoreboard on pending transfer), then advance past the rising edge.
  task automatic tick();
    exp_t x;
    @(negedge clk);
    if (out_valid && out_ready) begin
      n_xfer++;
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        x = sb.pop_front();
        chk("sb_digits", {q_tens, q_ones, r_tens, r_ones}, {x.qt, x.qo, x.rt, x.ro});
        chk("sb_err", {31'd0, err}, {31'd0, x.e});
        $display("xfer %0d: q=%0d%0d r=%0d%0d err=%0b", n_xfer, q_tens, q_ones, r_tens, r_ones, err);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [3:0] q, input logic [4:0] r);
    quotient  = q;
    remainder = r;
    div_done  = 1'b1;
    push_exp(q, r);
    tick();
    div_done  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (out_valid) break;
    end
  endtask

  initial begin
    rst = 1'b0; div_done = 1'b0; quotient = 4'd0; remainder = 5'd0; out_ready = 1'b0;
    #12;
    chk("rst_state", {30'd0, out_valid, busy}, 32'd0);
    chk("rst_digits", {16'd0, q_tens, q_ones, r_tens, r_ones}, 32'd0);
    chk("rst_flags", {30'd0, err, ovr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Basic conversion with consumer ready
    out_ready = 1'b1;
    capture(4'd13, 5'b00010);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_nvalid", {31'd0, out_valid}, 32'd0);
    wait_valid(lat);
    chk("t1_latency", lat, 32'd4);
    chk("t1_digits", {q_tens, q_ones, r_tens, r_ones}, 16'h1302);
    chk("t1_err", {31'd0, err}, 32'd0);
    tick();
    chk("t1_idle", {30'd0, out_valid, busy}, 32'd0);

    // Back-to-back: new div_done on the transfer edge
    capture(4'd4, 5'd3);
    wait_valid(lat);
    chk("t3_lat_a", lat, 32'd4);
    quotient = 4'd7; remainder = 5'd0; div_done = 1'b1;
    push_exp(4'd7, 5'd0);
    tick();
    div_done = 1'b0;
    chk("t3_conv", {30'd0, out_valid, busy}, 32'd1);
    chk("t3_ovr0", {31'd0, ovr}, 32'd0);
    wait_valid(lat);
    chk("t3_lat_b", lat, 32'd4);
    chk("t3_digits", {q_tens, q_ones, r_tens, r_ones}, 16'h0700);
    chk("t3_ovr1", {31'd0, ovr}, 32'd0);
    tick();

    // Stalled consumer; div_done in HOLD is dropped and flagged
    out_ready = 1'b0;
    capture(4'd15, 5'b01001);
    wait_valid(lat);
    chk("t2_latency", lat, 32'd4);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        quotient = 4'd2; remainder = 5'd1; div_done = 1'b1;
      end
      tick();
      div_done = 1'b0;
      chk("t2_hold", {11'd0, out_valid, q_tens, q_ones, r_tens, r_ones}, {11'd0, 1'b1, 16'h1509});
    end
    chk("t2_ovr", {31'd0, ovr}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("t2_xfer_idle", {30'd0, out_valid, busy}, 32'd0);

    // Bad remainder flagged, digits still from low nibble
    capture(4'd0, 5'b10011);
    wait_valid(lat);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_digits", {q_tens, q_ones, r_tens, r_ones}, 16'h0003);
    tick();

    // Reset mid-conversion aborts everything
    capture(4'd9, 5'd1);
    tick();
    rst = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("t5_rst_ctl", {30'd0, out_valid, busy}, 32'd0);
    chk("t5_rst_dig", {16'd0, q_tens, q_ones, r_tens, r_ones}, 32'd0);
    chk("t5_rst_flags", {30'd0, err, ovr}, 32'd0);
    #2;
    rst = 1'b1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid || busy) lat++;
    end
    chk("t5_no_valid", lat, 32'd0);

    // Fresh result after reset; err returns to 0
    capture(4'd10, 5'd0);
    wait_valid(lat);
    chk("t6_latency", lat, 32'd4);
    chk("t6_digits", {q_tens, q_ones, r_tens, r_ones}, 16'h1000);
    chk("t6_err", {31'd0, err}, 32'd0);
`ifdef DIV_SEG7_EN
    chk("t6_seg", {4'd0, seg_q_tens, seg_q_ones, seg_r_tens, seg_r_ones},
        {4'd0, 7'h06, 7'h3F, 7'h00, 7'h3F});
`endif
    tick();
    chk("sb_drained", sb.size(), 32'd0);
    chk("xfer_count", n_xfer, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
